// File: rtl/lfsr_run_ctrl_if.sv
// Run-control bundle between the LFSR BIST controller and its environment.
// The master side requests runs and supplies LFSR state; the slave reports.
interface lfsr_run_ctrl_if #(
    parameter int WIDTH     = 8,
    parameter int CNT_WIDTH = 16
);
    logic                 start;
    logic                 abort;
    logic [CNT_WIDTH-1:0] length;
    logic [WIDTH-1:0]     expected;
    logic [WIDTH-1:0]     lfsr_out;
    logic                 lfsr_reset;
    logic                 lfsr_enable;
    logic                 busy;
    logic                 done;
    logic                 pass;
    logic [WIDTH-1:0]     signature;

    modport master (
        output start, abort, length, expected, lfsr_out,
        input  lfsr_reset, lfsr_enable, busy, done, pass, signature
    );

    modport slave (
        input  start, abort, length, expected, lfsr_out,
        output lfsr_reset, lfsr_enable, busy, done, pass, signature
    );
endinterface

// File: rtl/lfsr_run_ctrl.sv
// Seeds an external LFSR to all ones, runs it for a latched number of
// steps while compressing its output into a signature, then compares.
module lfsr_run_ctrl #(
    parameter int               WIDTH     = 8,
    parameter int               CNT_WIDTH = 16,
    parameter logic [WIDTH-1:0] SIG_TAPS  = WIDTH'(8'b11101)
) (
    input  logic          clk,
    input  logic          reset,
    lfsr_run_ctrl_if.slave bus
);
    localparam int SW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        SEED,
        RUN,
        DONE
    } state_t;

    state_t               state;
    logic [CNT_WIDTH-1:0] cnt;
    logic [CNT_WIDTH-1:0] len;
    logic [SW-1:0]        seed_cnt;
    logic [WIDTH-1:0]     sig;
    logic [WIDTH-1:0]     sig_next;
    logic                 pass_q;
    logic                 seed_last;
    logic                 run_last;

    assign sig_next = {sig[WIDTH-2:0], 1'b0}
                    ^ (sig[WIDTH-1] ? SIG_TAPS : '0)
                    ^ bus.lfsr_out;

    assign seed_last = (seed_cnt == SW'(WIDTH - 1));
    // Counting to len-1 keeps the maximum length from wrapping the counter.
    assign run_last  = (cnt == len - CNT_WIDTH'(1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            cnt      <= '0;
            len      <= '0;
            seed_cnt <= '0;
            sig      <= '0;
            pass_q   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.start && (|bus.length)) begin
                        len      <= bus.length;
                        sig      <= '0;
                        pass_q   <= 1'b0;
                        cnt      <= '0;
                        seed_cnt <= '0;
                        state    <= SEED;
                    end
                end
                SEED: begin
                    if (bus.abort) begin
                        pass_q <= 1'b0;
                        state  <= IDLE;
                    end else if (seed_last) begin
                        cnt   <= '0;
                        state <= RUN;
                    end else begin
                        seed_cnt <= seed_cnt + SW'(1);
                    end
                end
                RUN: begin
                    if (bus.abort) begin
                        pass_q <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        sig <= sig_next;
                        if (run_last) begin
                            state <= DONE;
                        end else begin
                            cnt <= cnt + CNT_WIDTH'(1);
                        end
                    end
                end
                DONE: begin
                    pass_q <= (sig == bus.expected);
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.lfsr_reset  = (state == SEED);
    assign bus.lfsr_enable = (state == RUN);
    assign bus.busy        = (state == SEED) || (state == RUN);
    assign bus.done        = (state == DONE);
    assign bus.pass        = pass_q;
    assign bus.signature   = sig;
endmodule
